seg7_bcd_display: RTL
=====================

Name: seg7_bcd_display

Overview:
- Parametrised successor to the two-digit switch-to-7-segment decoder.
- Takes a WIDTH-bit unsigned binary value and converts it sequentially to BCD using shift-and-add-3 (double dabble), one bit per clock.
- Drives NDIGITS registered, active-low 7-segment digits, with optional leading-zero blanking and an overflow indication.
- Sits between datapath registers (counters, ALU results) and the board HEX displays, using a start/busy/done handshake.

Parameters:
- WIDTH, 8, bit width of the binary input value (≥1).
- NDIGITS, 3, number of decimal digits / 7-seg displays driven (≥1).

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; acted on only in IDLE.
- value  input  WIDTH  unsigned binary value, sampled on the accepting edge.
- blank_lz  input  1  leading-zero blanking enable, sampled with value.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when HEX and overflow have been updated.
- overflow  output  1  value exceeded 10^NDIGITS−1 on the last conversion.
- HEX  output  7*NDIGITS  segments; digit k occupies bits [7k+6:7k]; digit 0 is least significant; bit 0=a … bit 6=g; 0 = segment lit.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, overflow=0.
  - Every HEX digit = 7'h7F (blank).
  - Internal shift/BCD registers cleared.
  - Reset mid-conversion aborts the conversion with no partial display update.
- IDLE:
  - On an edge with start=1, latch value into the shift register and latch blank_lz.
  - Clear the BCD registers, the bit counter and the sticky overflow flag.
  - Go to SHIFT; busy=1 from that edge.
- SHIFT (exactly WIDTH cycles):
  - Each edge: every BCD digit ≥5 gets +3, then the {BCD, shift} chain shifts left by one.
  - The bit shifted out of the top digit is ORed into the sticky overflow flag.
  - After WIDTH shifts, go to UPDATE.
- UPDATE (1 cycle):
  - On its edge, write HEX from the BCD digits and overflow from the sticky flag.
  - done=1 for exactly one cycle; go to IDLE; busy=0.
- Latency:
  - busy is high for WIDTH+1 cycles.
  - HEX/done change WIDTH+1 edges after the accepting edge.
- Handshake:
  - start while busy=1 is ignored; it is not queued.
  - start high during the done cycle is accepted, allowing back-to-back conversions with a period of WIDTH+2 cycles.
  - value and blank_lz changes after the accepting edge have no effect.
- Digit encoding (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - blank=7F, dash=3F.
- Overflow:
  - All NDIGITS digits show dash (3F); blanking is not applied.
  - If 2^WIDTH−1 ≤ 10^NDIGITS−1, overflow can never assert.
- Leading-zero blanking (blank_lz=1, no overflow):
  - Zero digits above the most significant nonzero digit show 7F.
  - Digit 0 is never blanked, so value 0 shows "0".
- HEX holds its last value between conversions; no output glitches outside the UPDATE edge.

Test Plan:
- Reset, then hold idle 5 cycles -> HEX = 7F7F7F (all blank), busy=0, done=0, overflow=0.
- Defaults; value=255, blank_lz=0, start for 1 cycle -> busy high 9 cycles, done pulse at edge 9, HEX digits = 24,12,12 ("255"), overflow=0.
- Defaults; value=7, blank_lz=1 -> HEX = 7F,7F,78 (blank, blank, "7").
- value=0 with blank_lz=1 -> HEX = 7F,7F,40 (only digit 0 shows "0").
- WIDTH=8, NDIGITS=2:
  - value=100 -> overflow=1, HEX = 3F,3F.
  - A following conversion of value=99 -> overflow=0, HEX = 10,10.
- Handshake and reset:
  - Pulse start again mid-SHIFT -> ignored; exactly one done pulse.
  - start held high through done -> second conversion begins on the done edge.
  - Resetn low at SHIFT cycle 4 -> busy=0 and HEX blank immediately; no done pulse.

Source files
------------

// File: rtl/seg7_bcd_display.sv
// seg7_bcd_display: sequential binary-to-BCD converter (double dabble, one bit
// per clock) driving NDIGITS registered active-low 7-segment digits, with
// optional leading-zero blanking and an overflow (all-dash) indication.
//
// Handshake: a conversion is accepted on a rising edge where start=1 and the
// block is idle (busy=0; the done cycle counts as idle). busy rises on that
// edge and stays high for WIDTH+1 cycles. done is a one-cycle pulse on the
// cycle where HEX/overflow first show the new result. start while busy is
// dropped, never queued. value/blank_lz are only sampled on the accepting edge.
module seg7_bcd_display #(
  parameter int WIDTH   = 8,
  parameter int NDIGITS = 3
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   start,
  input  logic [WIDTH-1:0]       value,
  input  logic                   blank_lz,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [7*NDIGITS-1:0]   HEX,
  output logic [1:0]             o_dbg_state
);

  localparam int BW    = 4 * NDIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_shift;
  logic [BW-1:0]        r_bcd;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf_sticky;
  logic                 r_blank;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overflow;
  logic [7*NDIGITS-1:0] r_hex;

  logic [BW-1:0]        w_adj;
  logic [BW+WIDTH-1:0]  w_chain;
  logic [7*NDIGITS-1:0] w_hex;

  // Active-low segment pattern for one BCD digit (bit0=a .. bit6=g).
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Add-3 correction: every BCD digit >= 5 gets +3 before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < NDIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  // Corrected BCD and remaining binary bits shift left as one chain; the bit
  // leaving the top digit (w_adj[BW-1]) means the value does not fit.
  assign w_chain = {w_adj, r_shift} << 1;

  // Display image from the final BCD digits: dashes on overflow, otherwise
  // optional blanking of zero digits above the most significant nonzero one.
  always_comb begin
    logic seen;
    w_hex = '1;
    seen  = 1'b0;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      if (r_bcd[4*k +: 4] != 4'd0) seen = 1'b1;
      if (r_ovf_sticky)
        w_hex[7*k +: 7] = 7'h3F;
      else if (r_blank && !seen && (k != 0))
        w_hex[7*k +: 7] = 7'h7F;
      else
        w_hex[7*k +: 7] = seg_enc(r_bcd[4*k +: 4]);
    end
  end

  // Control FSM plus datapath; all outputs are registered here.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_ovf_sticky <= 1'b0;
      r_blank      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_hex        <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift      <= value;
            r_blank      <= blank_lz;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd        <= w_chain[BW+WIDTH-1:WIDTH];
          r_shift      <= w_chain[WIDTH-1:0];
          r_ovf_sticky <= r_ovf_sticky | w_adj[BW-1];
          r_cnt        <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_hex      <= w_hex;
          r_overflow <= r_ovf_sticky;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign overflow    = r_overflow;
  assign HEX         = r_hex;
  assign o_dbg_state = r_state;

endmodule
